// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC to instruction memory and fills the IF/ID register,
// handling stall, redirect, halt and end-of-memory.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  input  logic        HaltReq,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic        Busy,
  output logic        Halted,
  output logic        AddrError,
  output logic [31:0] FetchCount
);

  // 33 bits so a full 4 GiB memory limit still compares correctly.
  localparam logic [32:0] LimitBytes = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [31:0] LastWord   = 32'(LimitBytes - 33'd4);

  typedef enum logic [1:0] {StIdle, StFetch, StStall, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4;
  logic        bad_target;

  assign pc_plus4   = pc_q + 32'd4;
  assign bad_target = (RedirectAddr[1:0] != 2'b00) || ({1'b0, RedirectAddr} >= LimitBytes);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (Start) state_d = StFetch;
      end
      StFetch, StStall: begin
        if (HaltReq) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
          state_d = StHalt;
        end else if (Redirect) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (bad_target) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d    = RedirectAddr;
            state_d = StFetch;
          end
        end else if (Stall) begin
          state_d = StStall;
        end else begin
          instr_d = ImemInstruction;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
          // Last word delivered: stop rather than let PC run past memory.
          state_d = (pc_q == LastWord) ? StHalt : StFetch;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      count_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ImemAddress     = pc_q;
  assign PC              = pc_q;
  assign IfIdInstruction = instr_q;
  assign IfIdPCPlus4     = pc4_q;
  assign IfIdValid       = valid_q;
  assign FetchCount      = count_q;
  assign AddrError       = err_q;
  assign Busy            = (state_q == StFetch) || (state_q == StStall);
  assign Halted          = (state_q == StHalt);

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, the address loaded into PC on reset.
REQ-002 Parameter IMEM_WORDS, default 1024, the instruction-memory depth in words; the byte limit is IMEM_WORDS*4.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle pulse that leaves IDLE.
REQ-006 Stall  input  1  hazard stall request from the decode stage.
REQ-007 Redirect  input  1  taken branch or jump request.
REQ-008 RedirectAddr  input  32  target byte address for Redirect.
REQ-009 HaltReq  input  1  external halt request.
REQ-010 ImemAddress  output  32  byte address driven to instruction memory.
REQ-011 ImemInstruction  input  32  combinational read data for ImemAddress.
REQ-012 PC  output  32  current fetch program counter.
REQ-013 IfIdInstruction  output  32  registered fetched instruction.
REQ-014 IfIdPCPlus4  output  32  registered PC+4 of that instruction.
REQ-015 IfIdValid  output  1  IF/ID contents are a real instruction.
REQ-016 Busy  output  1  high in FETCH or STALL.
REQ-017 Halted  output  1  high in HALT.
REQ-018 AddrError  output  1  sticky flag for a bad redirect target.
REQ-019 FetchCount  output  32  number of instructions delivered with IfIdValid=1.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, STALL and HALT.
REQ-021 ImemAddress SHALL equal PC combinationally, with zero added latency; instruction data is captured into IF/ID on the same edge.
REQ-022 IDLE: hold PC; IfIdValid=0; Start=1 moves to FETCH.
REQ-023 FETCH, no other event: IfIdInstruction<=ImemInstruction, IfIdPCPlus4<=PC+4, IfIdValid<=1, PC<=PC+4, FetchCount<=FetchCount+1.
REQ-024 Stall=1 in FETCH or STALL SHALL hold PC and all IF/ID registers unchanged and select STALL; Stall=0 in STALL returns to FETCH.
REQ-025 Redirect=1 in FETCH or STALL SHALL have priority over Stall.
REQ-026 Redirect effect: PC<=RedirectAddr, IfIdInstruction<=32'h0 (nop), IfIdValid<=0, FetchCount unchanged, next state FETCH.
REQ-027 A bad redirect target is RedirectAddr[1:0]!=0 or RedirectAddr>=IMEM_WORDS*4.
REQ-028 On a bad redirect target, AddrError<=1, PC is held, IF/ID is flushed, and the FSM goes to HALT.
REQ-029 HaltReq=1 in FETCH or STALL SHALL have priority over Redirect and Stall: flush IF/ID, hold PC, go to HALT.
REQ-030 End of memory: when PC=IMEM_WORDS*4-4 in FETCH with no other event, the last word SHALL be delivered normally, PC<=IMEM_WORDS*4, and the FSM goes to HALT. The PC SHALL never wrap to 0.
REQ-031 HALT is absorbing: IfIdValid=0, PC frozen, and inputs other than Reset are ignored.
REQ-032 Start in any state other than IDLE SHALL be ignored; Redirect and Stall in IDLE SHALL be ignored.
REQ-033 PC+4 and FetchCount SHALL use 32-bit unsigned arithmetic; FetchCount wraps modulo 2^32.
REQ-034 Busy=(state==FETCH||state==STALL); Halted=(state==HALT).

Reset
REQ-035 Reset=1 SHALL override all other inputs in every state, including mid-stall and HALT.
REQ-036 Reset values: state IDLE, PC=PC_RESET, IfIdInstruction=0, IfIdPCPlus4=0, IfIdValid=0, FetchCount=0, AddrError=0, Busy=0, Halted=0.
REQ-037 During reset, ImemAddress SHALL equal PC_RESET.

Verification
REQ-038 Reset, Start, 3 free cycles with mem[i]=i*3 -> IfIdInstruction 0,3,6; IfIdPCPlus4 4,8,12; PC=12; FetchCount=3.
REQ-039 Stall held 2 cycles at PC=8 -> PC stays 8 and IF/ID unchanged for both cycles; after release, mem[2] (=6) is delivered.
REQ-040 Stall and Redirect together, RedirectAddr=0x40 -> PC=0x40, IfIdValid=0, IfIdInstruction=0; next cycle IfIdInstruction=48, IfIdPCPlus4=0x44.
REQ-041 Redirect to 0x42, and separately to 0x1000 with IMEM_WORDS=1024 -> AddrError=1, Halted=1, PC unchanged; stays halted until Reset.
REQ-042 IMEM_WORDS=4, run from 0 -> 4 valid deliveries, then Halted=1, PC=16, FetchCount=4.
REQ-043 Reset asserted during STALL and during HALT -> all outputs at the REQ-036 values next cycle; Start then restarts fetch at PC_RESET.
